// File: rtl/parkimetro_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parkimetro_pkg : shared parking-lot encodings (barrier state, sensor codes)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
package parkimetro_pkg;

   typedef enum logic [1:0] {
      CERRADA = 2'b00,
      ABIERTA = 2'b01,
      REARME  = 2'b10
   } estado_barrera_t;

   // Sensor pair codes, also produced by the sensor_autos passage detector
   typedef enum logic [1:0] {
      inactivo   = 2'b00,
      solo_entra = 2'b01,
      solo_sale  = 2'b10,
      invalido   = 2'b11
   } par_sensor_t;

endpackage
`default_nettype wire

// File: rtl/temporizador_barrera.sv
`default_nettype none
// ---------------------------------------------------------------------------
// temporizador_barrera : loadable down-counter holding the barrier open window
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module temporizador_barrera #(
   parameter int TIMEOUT = 64,
   localparam int W = $clog2(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic cero
);

   localparam logic [W-1:0] CARGA = W'(TIMEOUT - 1);

   logic [W-1:0] cuenta;

   always_ff @(posedge clk) begin
      if (reset) begin
         cuenta <= '0;
      end else if (load) begin
         cuenta <= CARGA;
      end else if (en && (cuenta != '0)) begin
         cuenta <= cuenta - 1'b1;
      end
   end

   assign cero = (cuenta == '0);

endmodule
`default_nettype wire

// File: rtl/control_barrera_entrada.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_barrera_entrada : entry barrier FSM plus lot occupancy counter
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module control_barrera_entrada
   import parkimetro_pkg::*;
#(
   parameter int CAPACIDAD = 16,
   parameter int TIMEOUT   = 64,
   localparam int CNT_W    = $clog2(CAPACIDAD + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_entrada,
   input  logic             tick_entrada,
   input  logic             tick_salida,
   output logic             barrera_abierta,
   output logic             lleno,
   output logic [CNT_W-1:0] ocupacion,
   output logic             timeout,
   output logic             error
);

   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACIDAD);

   estado_barrera_t estado;
   logic            cero;
   logic            abrir;
   logic            entrada_ok;

   // The full check looks only at the registered count, so an exit in the
   // same cycle opens the barrier one cycle later.
   assign abrir      = (estado == CERRADA) && req_entrada && (ocupacion < CAP);
   assign entrada_ok = (estado == ABIERTA) && tick_entrada;

   temporizador_barrera #(
      .TIMEOUT (TIMEOUT)
   ) u_temporizador (
      .clk   (clk),
      .reset (reset),
      .load  (abrir),
      .en    ((estado == ABIERTA) && !tick_entrada),
      .cero  (cero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         estado          <= CERRADA;
         barrera_abierta <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (estado)
            CERRADA: begin
               if (abrir) begin
                  estado          <= ABIERTA;
                  barrera_abierta <= 1'b1;
               end
            end
            ABIERTA: begin
               // A passage in the last open cycle wins over the timeout
               if (tick_entrada) begin
                  estado          <= REARME;
                  barrera_abierta <= 1'b0;
               end else if (cero) begin
                  estado          <= REARME;
                  barrera_abierta <= 1'b0;
                  timeout         <= 1'b1;
               end
            end
            REARME: begin
               if (!req_entrada) begin
                  estado <= CERRADA;
               end
            end
            default: begin
               estado          <= CERRADA;
               barrera_abierta <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ocupacion <= '0;
         error     <= 1'b0;
      end else begin
         error <= (tick_entrada && (estado != ABIERTA)) ||
                  (tick_salida && !entrada_ok && (ocupacion == '0));
         if (entrada_ok && !tick_salida && (ocupacion != CAP)) begin
            ocupacion <= ocupacion + 1'b1;
         end else if (!entrada_ok && tick_salida && (ocupacion != '0)) begin
            ocupacion <= ocupacion - 1'b1;
         end
      end
   end

   assign lleno = (ocupacion == CAP);

endmodule
`default_nettype wire

// File: tb/tb_control_barrera_entrada.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_control_barrera_entrada : vector table + scoreboard bench, CAPACIDAD=4, TIMEOUT=8
// ---------------------------------------------------------------------------
module tb_control_barrera_entrada;

   localparam int CAPACIDAD = 4;
   localparam int TIMEOUT   = 8;
   localparam int CNT_W     = $clog2(CAPACIDAD + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             req_entrada;
   logic             tick_entrada;
   logic             tick_salida;
   logic             barrera_abierta;
   logic             lleno;
   logic [CNT_W-1:0] ocupacion;
   logic             timeout;
   logic             error;

   control_barrera_entrada #(
      .CAPACIDAD (CAPACIDAD),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_entrada     (req_entrada),
      .tick_entrada    (tick_entrada),
      .tick_salida     (tick_salida),
      .barrera_abierta (barrera_abierta),
      .lleno           (lleno),
      .ocupacion       (ocupacion),
      .timeout         (timeout),
      .error           (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rst, req, te, ts;
      logic             bar, ll;
      logic [CNT_W-1:0] oc;
      logic             to, er;
   } vec_t;

   typedef struct {
      int               idx;
      logic             bar, ll;
      logic [CNT_W-1:0] oc;
      logic             to, er;
   } esperado_t;

   vec_t      tabla[$];
   esperado_t sb[$];
   int        n_chk  = 0;
   int        n_fail = 0;

   function automatic void agrega(logic rst, logic req, logic te, logic ts,
                                  logic bar, logic ll, logic [CNT_W-1:0] oc,
                                  logic to, logic er);
      vec_t v;
      v.rst = rst; v.req = req; v.te = te; v.ts = ts;
      v.bar = bar; v.ll = ll; v.oc = oc; v.to = to; v.er = er;
      tabla.push_back(v);
   endfunction

   // One complete car entry starting from CERRADA with occupancy oc
   function automatic void entra(logic [CNT_W-1:0] oc);
      logic [CNT_W-1:0] nx;
      nx = oc + 1'b1;
      agrega(0, 1, 0, 0, 1, 0, oc, 0, 0);
      agrega(0, 1, 1, 0, 0, (nx == CAPACIDAD), nx, 0, 0);
      agrega(0, 0, 0, 0, 0, (nx == CAPACIDAD), nx, 0, 0);
   endfunction

   task automatic chk(string nombre, int got, int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nombre, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      esperado_t e;
      int n_open, n_to, n_to_ok;
      logic prev_bar;

      // Reset
      agrega(1, 0, 0, 0, 0, 0, 0, 0, 0);
      agrega(1, 1, 1, 1, 0, 0, 0, 0, 0);
      // Entry with a passage 5 cycles after opening, then one car per request
      agrega(0, 1, 0, 0, 1, 0, 0, 0, 0);
      repeat (4) agrega(0, 1, 0, 0, 1, 0, 0, 0, 0);
      agrega(0, 1, 1, 0, 0, 0, 1, 0, 0);
      repeat (2) agrega(0, 1, 0, 0, 0, 0, 1, 0, 0);
      agrega(0, 0, 0, 0, 0, 0, 1, 0, 0);
      // Timeout: open for exactly TIMEOUT cycles, one timeout pulse
      repeat (TIMEOUT) agrega(0, 1, 0, 0, 1, 0, 1, 0, 0);
      agrega(0, 1, 0, 0, 0, 0, 1, 1, 0);
      agrega(0, 1, 0, 0, 0, 0, 1, 0, 0);
      agrega(0, 0, 0, 0, 0, 0, 1, 0, 0);
      // Fill the lot, request while full, exit frees a space
      entra(1); entra(2); entra(3);
      repeat (2) agrega(0, 1, 0, 0, 0, 1, 4, 0, 0);
      agrega(0, 1, 0, 1, 0, 0, 3, 0, 0);
      agrega(0, 1, 0, 0, 1, 0, 3, 0, 0);
      agrega(0, 1, 1, 0, 0, 1, 4, 0, 0);
      agrega(0, 0, 0, 0, 0, 1, 4, 0, 0);
      // Simultaneous entry and exit, then exits down past zero
      agrega(0, 0, 0, 1, 0, 0, 3, 0, 0);
      agrega(0, 0, 0, 1, 0, 0, 2, 0, 0);
      agrega(0, 1, 0, 0, 1, 0, 2, 0, 0);
      agrega(0, 1, 1, 1, 0, 0, 2, 0, 0);
      agrega(0, 0, 0, 0, 0, 0, 2, 0, 0);
      agrega(0, 0, 0, 1, 0, 0, 1, 0, 0);
      agrega(0, 0, 0, 1, 0, 0, 0, 0, 0);
      agrega(0, 0, 0, 1, 0, 0, 0, 0, 1);
      agrega(0, 0, 0, 1, 0, 0, 0, 0, 1);
      agrega(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Entry tick while closed
      agrega(0, 0, 1, 0, 0, 0, 0, 0, 1);
      agrega(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Passage in the last open cycle counts, no timeout
      repeat (TIMEOUT) agrega(0, 1, 0, 0, 1, 0, 0, 0, 0);
      agrega(0, 1, 1, 0, 0, 0, 1, 0, 0);
      agrega(0, 0, 0, 0, 0, 0, 1, 0, 0);
      // Reset while open with occupancy 3
      entra(1); entra(2);
      agrega(0, 1, 0, 0, 1, 0, 3, 0, 0);
      agrega(1, 1, 1, 1, 0, 0, 0, 0, 0);
      agrega(0, 0, 0, 0, 0, 0, 0, 0, 0);

      reset = 1'b1; req_entrada = 1'b0; tick_entrada = 1'b0; tick_salida = 1'b0;
      @(posedge clk); #1;

      foreach (tabla[i]) begin
         reset        = tabla[i].rst;
         req_entrada  = tabla[i].req;
         tick_entrada = tabla[i].te;
         tick_salida  = tabla[i].ts;
         e.idx = i; e.bar = tabla[i].bar; e.ll = tabla[i].ll;
         e.oc = tabla[i].oc; e.to = tabla[i].to; e.er = tabla[i].er;
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_chk++;
         if (barrera_abierta !== e.bar || lleno !== e.ll || ocupacion !== e.oc ||
             timeout !== e.to || error !== e.er) begin
            n_fail++;
            $display("FAIL vec %0d: got bar=%b lleno=%b ocup=%0d to=%b err=%b, expected bar=%b lleno=%b ocup=%0d to=%b err=%b",
                     e.idx, barrera_abierta, lleno, ocupacion, timeout, error,
                     e.bar, e.ll, e.oc, e.to, e.er);
         end
      end

      // Held request after reset: measure open window and timeout alignment
      reset = 1'b0; tick_entrada = 1'b0; tick_salida = 1'b0; req_entrada = 1'b1;
      n_open = 0; n_to = 0; n_to_ok = 0; prev_bar = barrera_abierta;
      for (int c = 0; c < 3 * TIMEOUT; c++) begin
         @(posedge clk); #1;
         if (barrera_abierta) n_open++;
         if (timeout) begin
            n_to++;
            if (prev_bar && !barrera_abierta) n_to_ok++;
         end
         prev_bar = barrera_abierta;
      end
      req_entrada = 1'b0;
      chk("open_cycles", n_open, TIMEOUT);
      chk("timeout_pulses", n_to, 1);
      chk("timeout_on_close", n_to_ok, 1);
      chk("ocup_after_timeout", int'(ocupacion), 0);
      @(posedge clk); #1;
      chk("error_idle", int'(error), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
